alu_share_arbiter: RTL

//  Shares one aluV_8 instance between NREQ requesters (e.g. PC incrementer, branch compare,

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_share_arbiter_rr_pick.sv | 35 +++
 rtl/alu_share_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter FSM encodings.
// Imported by the arbiter top and its round-robin picker.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after last_i,
// wrapping; returns one-hot grant plus its index.
module rr_pick
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 8-bit ALU among NREQ requesters with
// round-robin grant and a registered IDLE/EXEC/RESP sequence.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*CW-1:0] req_ctrl,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carryout,
  output logic              rsp_overflow,
  output logic [CW-1:0]     alu_ctrl,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic              alu_zero,
  input  logic              alu_carryout,
  input  logic              alu_overflow,
  input  logic [DW-1:0]     alu_result
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any_req;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (any_req)
  );

  assign req_ready = (state_q == S_IDLE) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= IW'(NREQ - 1);
      alu_ctrl     <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            alu_ctrl <= req_ctrl[gnt_idx*CW +: CW];
            alu_a    <= req_a[gnt_idx*DW +: DW];
            alu_b    <= req_b[gnt_idx*DW +: DW];
            owner_q  <= gnt_idx;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_carryout <= alu_carryout;
          rsp_overflow <= alu_overflow;
          rsp_valid    <= NREQ'(1) << owner_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            last_q    <= owner_q;
            rsp_valid <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
